mem_responder: RTL and testbench

- Memory-side responder for the multicycle RV32 core. It services the core's load and store requests over a valid/ready request channel and a valid/ready response channel.
- Holds a word-organised data RAM. Performs byte, half and word access with sign or zero extension, and inserts a configurable number of wait states.
- Flags misaligned, out-of-range and illegal-size accesses with an error response, so the core controller can stall or trap instead of assuming single-cycle memory.

---
 rtl/mem_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the multicycle RV32 core. Services load/store
//   requests from a word-organised RAM with byte/half/word access, sign or
//   zero extension, a configurable number of wait states, and an error flag
//   for misaligned, out-of-range and illegal-size accesses.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder can accept a request (IDLE only)
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_funct3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_wdata   store data, right-aligned
//   rsp_valid   response present
//   rsp_ready   requester accepts the response
//   rsp_rdata   load result, extended; 0 for stores and errors
//   rsp_err     access faulted; qualified by rsp_valid
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a request; request fields are latched on accept
// S_WAIT | wait-state down-counter running; commit when it reaches 0
// S_RESP | response presented; held until rsp_ready
module mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [2:0]        lat_funct3;
  logic [31:0]       lat_wdata;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              commit_now;
  logic              mem_we;
  logic              c_write;
  logic [ADDR_W-1:0] c_addr;
  logic [2:0]        c_funct3;
  logic [31:0]       c_wdata;
  logic [ADDR_W-3:0] c_word;
  logic [IDX_W-1:0]  c_idx;
  logic              c_oob;
  logic              c_f3_bad;
  logic              c_misalign;
  logic              c_err;
  logic [31:0]       old_word;
  logic [3:0]        be;
  logic [31:0]       st_data;
  logic [31:0]       merged;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       ld_data;
  logic [31:0]       c_rdata;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  // With zero wait states the commit happens on the accept edge itself, so the
  // commit path reads the live request in IDLE and the latched copy otherwise.
  assign commit_now = ((state == S_WAIT) && (wait_cnt == 4'd0)) ||
                      ((WAIT_CYCLES == 0) && accept);

  assign c_write  = (state == S_IDLE) ? req_write  : lat_write;
  assign c_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
  assign c_funct3 = (state == S_IDLE) ? req_funct3 : lat_funct3;
  assign c_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;

  assign c_word = c_addr[ADDR_W-1:2];
  assign c_idx  = c_addr[IDX_W+1:2];
  assign c_oob  = ({1'b0, c_word} >= (ADDR_W-1)'(DEPTH));

  always_comb begin
    c_f3_bad = 1'b1;
    case (c_funct3)
      3'b000, 3'b001, 3'b010: c_f3_bad = 1'b0;
      3'b100, 3'b101:         c_f3_bad = c_write;
      default:                c_f3_bad = 1'b1;
    endcase
  end

  always_comb begin
    c_misalign = 1'b0;
    case (c_funct3[1:0])
      2'b01:   c_misalign = c_addr[0];
      2'b10:   c_misalign = (c_addr[1:0] != 2'b00);
      default: c_misalign = 1'b0;
    endcase
  end

  assign c_err    = c_f3_bad || c_misalign || c_oob;
  assign old_word = mem[c_idx];

  // Store data is replicated across lanes; the byte enables pick which lanes land.
  always_comb begin
    be      = 4'b0000;
    st_data = 32'h0;
    case (c_funct3[1:0])
      2'b00: begin
        be      = 4'b0001 << c_addr[1:0];
        st_data = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        be      = c_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{c_wdata[15:0]}};
      end
      2'b10: begin
        be      = 4'b1111;
        st_data = c_wdata;
      end
      default: begin
        be      = 4'b0000;
        st_data = 32'h0;
      end
    endcase
  end

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = st_data[8*i +: 8];
    end
  end

  assign byte_sel = old_word[{c_addr[1:0], 3'b000} +: 8];
  assign half_sel = c_addr[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    ld_data = 32'h0;
    case (c_funct3)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  ld_data = old_word;
      3'b100:  ld_data = {24'h0, byte_sel};
      3'b101:  ld_data = {16'h0, half_sel};
      default: ld_data = 32'h0;
    endcase
  end

  assign c_rdata = (c_err || c_write) ? 32'h0 : ld_data;

  // Gate with rst_n so a store cannot land on a clock edge that the FSM
  // ignores because reset is being held.
  assign mem_we = rst_n && commit_now && c_write && !c_err;

  always_ff @(posedge clk) begin
    if (mem_we) mem[c_idx] <= merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_funct3 <= 3'b000;
      lat_wdata  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_write  <= req_write;
            lat_addr   <= req_addr;
            lat_funct3 <= req_funct3;
            lat_wdata  <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= c_rdata;
              rsp_err   <= c_err;
              state     <= S_RESP;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= c_rdata;
            rsp_err   <= c_err;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          // rdata/err keep their values after the handshake; only valid drops.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic        rsp_ready  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];

  int checks   = 0;
  int failures = 0;
  int lat_exp [3] = '{1, 2, 4};

  // Reference memory for the WAIT_CYCLES=1 instance, kept as a flat byte array.
  logic [7:0] mb [DEPTH*4];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    int          hold;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [$];

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .ADDR_W(32)) dut_w0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_funct3(req_funct3[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1), .ADDR_W(32)) dut_w1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_funct3(req_funct3[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .ADDR_W(32)) dut_w3 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_funct3(req_funct3[2]),
    .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_exec(input bit wr, input logic [31:0] addr, input logic [2:0] f3,
                                     input logic [31:0] wd, output logic [31:0] rd, output bit err);
    int size;
    bit sgn;
    bit bad;
    longint a;
    int ia;
    logic [31:0] v;
    size = 1; sgn = 0; bad = 0;
    case (f3)
      3'b000: begin size = 1; sgn = 1; end
      3'b001: begin size = 2; sgn = 1; end
      3'b010: begin size = 4; end
      3'b100: begin size = 1; bad = wr; end
      3'b101: begin size = 2; bad = wr; end
      default: bad = 1;
    endcase
    a = longint'(addr);
    err = bad || ((a % size) != 0) || ((a / 4) >= DEPTH);
    rd = 32'h0;
    if (!err) begin
      ia = int'(a);
      if (wr) begin
        for (int b = 0; b < size; b++) mb[ia + b] = wd[8*b +: 8];
      end else begin
        v = 32'h0;
        for (int b = 0; b < size; b++) v[8*b +: 8] = mb[ia + b];
        if (sgn && v[8*size-1]) begin
          for (int b = size; b < 4; b++) v[8*b +: 8] = 8'hFF;
        end
        rd = v;
      end
    end
  endfunction

  task automatic do_txn(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_write[d]  = wr;
    req_addr[d]   = addr;
    req_funct3[d] = f3;
    req_wdata[d]  = wd;
    req_valid[d]  = 1'b1;
    rsp_ready[d]  = 1'b0;
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Scramble request inputs after accept; they must be ignored.
        req_valid[d]  = 1'b0;
        req_write[d]  = 1'($urandom);
        req_addr[d]   = $urandom;
        req_funct3[d] = 3'($urandom);
        req_wdata[d]  = $urandom;
      end
      if (rsp_valid[d]) begin
        lat = k;
        break;
      end
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout dut=%0d actual=no_response expected=rsp_valid", d);
      return;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      req_valid[d] = 1'($urandom);
      req_addr[d]  = $urandom;
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], rd);
      chk("hold_err", 32'(rsp_err[d]), 32'(er));
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk("post_hs_req_ready", 32'(req_ready[d]), 32'd1);
    chk("post_hs_rsp_valid", 32'(rsp_valid[d]), 32'd0);
  endtask

  task automatic run_check(input string tag, input int d, input bit wr, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] wd, input int hold,
                           input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] rd;
    logic er;
    int lat;
    do_txn(d, wr, addr, f3, wd, hold, rd, er, lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_latency"}, 32'(lat), 32'(lat_exp[d]));
  endtask

  initial begin
    logic [31:0] erd;
    bit eerr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0] f3;
    bit wr;
    int sel;
    int seen;

    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'h0;
      req_funct3[d] = 3'b000; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset_req_ready", 32'(req_ready[d]), 32'd1);
      chk("reset_rsp_rdata", rsp_rdata[d], 32'h0);
      chk("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
      rst_n[d] = 1'b1;
    end

    // ---------------- WAIT_CYCLES=1: fill RAM through the model ----------------
    for (int w = 0; w < DEPTH; w++) begin
      wd = $urandom;
      model_exec(1'b1, 32'(w * 4), 3'b010, wd, erd, eerr);
      run_check("init_sw", 1, 1'b1, 32'(w * 4), 3'b010, wd, 0, erd, eerr);
    end

    // ---------------- directed vector table ----------------
    tbl.push_back('{1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, 32'h0,       1'b0});
    tbl.push_back('{1'b0, 32'h10, 3'b010, 32'h0,       0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h12, 3'b000, 32'h00000055, 0, 32'h0,      1'b0});
    tbl.push_back('{1'b0, 32'h10, 3'b010, 32'h0,       0, 32'hDE55BEEF, 1'b0});
    tbl.push_back('{1'b0, 32'h12, 3'b000, 32'h0,       0, 32'h00000055, 1'b0});
    tbl.push_back('{1'b0, 32'h13, 3'b000, 32'h0,       0, 32'hFFFFFFDE, 1'b0});
    tbl.push_back('{1'b0, 32'h13, 3'b100, 32'h0,       0, 32'h000000DE, 1'b0});
    tbl.push_back('{1'b0, 32'h10, 3'b001, 32'h0,       5, 32'hFFFFBEEF, 1'b0});
    tbl.push_back('{1'b0, 32'h12, 3'b101, 32'h0,       0, 32'h0000DE55, 1'b0});
    tbl.push_back('{1'b0, 32'h11, 3'b010, 32'h0,       0, 32'h0,        1'b1});
    tbl.push_back('{1'b1, 32'h13, 3'b001, 32'h00001234, 0, 32'h0,      1'b1});
    tbl.push_back('{1'b0, 32'h10, 3'b010, 32'h0,       0, 32'hDE55BEEF, 1'b0});
    tbl.push_back('{1'b0, 32'(DEPTH*4), 3'b010, 32'h0, 0, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h10, 3'b011, 32'h0,       0, 32'h0,        1'b1});
    tbl.push_back('{1'b1, 32'h10, 3'b100, 32'h000000AA, 0, 32'h0,      1'b1});
    tbl.push_back('{1'b0, 32'h10, 3'b010, 32'h0,       0, 32'hDE55BEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h12, 3'b001, 32'h0000CAFE, 0, 32'h0,      1'b0});
    tbl.push_back('{1'b0, 32'h10, 3'b010, 32'h0,       3, 32'hCAFEBEEF, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      model_exec(tbl[i].wr, tbl[i].addr, tbl[i].f3, tbl[i].wd, erd, eerr);
      run_check($sformatf("vec%0d", i), 1, tbl[i].wr, tbl[i].addr, tbl[i].f3, tbl[i].wd,
                tbl[i].hold, tbl[i].exp_rd, tbl[i].exp_err);
    end

    // ---------------- randomized traffic against the model ----------------
    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = $urandom;
      else if (sel == 1) addr = 32'(DEPTH * 4 + $urandom_range(0, 15));
      else               addr = 32'($urandom_range(0, DEPTH * 4 - 1));
      wr = 1'($urandom);
      f3 = 3'($urandom);
      wd = $urandom;
      model_exec(wr, addr, f3, wd, erd, eerr);
      run_check("rand", 1, wr, addr, f3, wd, $urandom_range(0, 3), erd, eerr);
    end

    // ---------------- WAIT_CYCLES=0 ----------------
    run_check("w0_sw", 0, 1'b1, 32'h8, 3'b010, 32'h0BADF00D, 0, 32'h0, 1'b0);
    run_check("w0_lw", 0, 1'b0, 32'h8, 3'b010, 32'h0, 0, 32'h0BADF00D, 1'b0);
    run_check("w0_lhu", 0, 1'b0, 32'hA, 3'b101, 32'h0, 0, 32'h00000BAD, 1'b0);
    @(negedge clk);
    req_write[0] = 1'b0; req_addr[0] = 32'h8; req_funct3[0] = 3'b010;
    req_valid[0] = 1'b1; rsp_ready[0] = 1'b1;
    chk("b2b_start_ready", 32'(req_ready[0]), 32'd1);
    seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 8) req_valid[0] = 1'b0;
      chk("b2b_rsp_valid", 32'(rsp_valid[0]), 32'(k % 2));
      chk("b2b_req_ready", 32'(req_ready[0]), 32'((k + 1) % 2));
      if (rsp_valid[0]) begin
        seen++;
        chk("b2b_rdata", rsp_rdata[0], 32'h0BADF00D);
      end
    end
    chk("b2b_responses", 32'(seen), 32'd4);
    rsp_ready[0] = 1'b0;

    // ---------------- WAIT_CYCLES=3 with reset in WAIT ----------------
    run_check("w3_sw_old", 2, 1'b1, 32'h20, 3'b010, 32'hAAAAAAAA, 0, 32'h0, 1'b0);
    run_check("w3_lw_old", 2, 1'b0, 32'h20, 3'b010, 32'h0, 0, 32'hAAAAAAAA, 1'b0);
    @(negedge clk);
    req_write[2] = 1'b1; req_addr[2] = 32'h20; req_funct3[2] = 3'b010;
    req_wdata[2] = 32'h12345678; req_valid[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("w3_in_wait_req_ready", 32'(req_ready[2]), 32'd0);
    chk("w3_in_wait_rdata_held", rsp_rdata[2], 32'hAAAAAAAA);
    #1 rst_n[2] = 1'b0;
    #1;
    chk("w3_async_rst_valid", 32'(rsp_valid[2]), 32'd0);
    chk("w3_async_rst_req_ready", 32'(req_ready[2]), 32'd1);
    chk("w3_async_rst_rdata", rsp_rdata[2], 32'h0);
    chk("w3_async_rst_err", 32'(rsp_err[2]), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    run_check("w3_lw_after_rst", 2, 1'b0, 32'h20, 3'b010, 32'h0, 0, 32'hAAAAAAAA, 1'b0);

    // Store already in RESP when reset hits has committed.
    @(negedge clk);
    req_write[2] = 1'b1; req_addr[2] = 32'h24; req_funct3[2] = 3'b010;
    req_wdata[2] = 32'h11223344; req_valid[2] = 1'b1;
    @(posedge clk);
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req_valid[2] = 1'b0;
      if (rsp_valid[2]) begin
        seen = 1;
        break;
      end
    end
    chk("w3_resp_reached", 32'(seen), 32'd1);
    #1 rst_n[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    run_check("w3_committed", 2, 1'b0, 32'h24, 3'b010, 32'h0, 0, 32'h11223344, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
